// File: rtl/wave_shaper.sv
// -----------------------------------------------------------------------------
// wave_shaper
//
// Converts the frequency generator's phase counter into an 8-bit phase
// fraction q = floor(((count-1) << 8) / divider) with an 8-step restoring
// divider. It then shapes q into one of four waveforms, scales the result by
// the envelope level and presents a registered sample.
//
// One sample takes 9 cycles from an accepted sample_tick to the sample_valid
// pulse. A new tick is accepted on the same edge that completes a sample.
//
// Optional feature macro: SYNTH_ENV_EN
//   defined   : attack/sustain/release envelope FSM and the sample multiplier
//               are built in.
//   undefined : env_level is a registered copy of the gate (note_on ? 255 : 0),
//               and the raw waveform is gated by note_on. env_tick,
//               attack_step and release_step are ignored.
//
// Ports
//   clk           system clock, rising edge
//   nrst          synchronous active-low reset
//   count         phase counter from the frequency generator (1..divider)
//   divider       period length of the frequency generator
//   note_on       note gate
//   mode          0 square, 1 sawtooth, 2 triangle, 3 falling saw
//   sample_tick   one-cycle sample request; ignored while busy
//   env_tick      one-cycle envelope update strobe
//   attack_step   envelope increment per env_tick in ATTACK (0 means 255)
//   release_step  envelope decrement per env_tick in RELEASE (0 means 255)
//   sample        shaped and scaled sample, held between updates
//   sample_valid  one-cycle pulse when sample updates
//   busy          divider running
//   env_level     current envelope amplitude
// -----------------------------------------------------------------------------
module wave_shaper (
  input  logic        clk,
  input  logic        nrst,
  input  logic [15:0] count,
  input  logic [15:0] divider,
  input  logic        note_on,
  input  logic [1:0]  mode,
  input  logic        sample_tick,
  input  logic        env_tick,
  input  logic [7:0]  attack_step,
  input  logic [7:0]  release_step,
  output logic [7:0]  sample,
  output logic        sample_valid,
  output logic        busy,
  output logic [7:0]  env_level
);

  localparam logic [3:0] LAST_ITER = 4'd8;

  logic        busy_q,   busy_d;
  logic [3:0]  iter_q,   iter_d;
  logic [15:0] rem_q,    rem_d;
  logic [15:0] div_q,    div_d;
  logic [7:0]  quo_q,    quo_d;
  logic [1:0]  mode_q,   mode_d;
  logic        guard_q,  guard_d;
  logic [7:0]  sample_q, sample_d;
  logic        valid_q,  valid_d;
  logic [7:0]  env_q,    env_d;

  logic        finish;
  logic        accept;
  logic [16:0] rem_shift;
  logic [16:0] rem_next;
  logic        rem_ge;
  logic [7:0]  q_final;
  logic [7:0]  raw;
  logic [7:0]  scaled;
  logic        unused_bits;

  // The final edge of a division may also accept the next request,
  // which gives a back-to-back period of 9 cycles.
  assign finish = busy_q && (iter_q == LAST_ITER);
  assign accept = sample_tick && (!busy_q || finish);

  // One restoring step. The remainder always stays below the divisor, so
  // after the shift it fits in 17 bits, and after a subtraction it fits in 16.
  assign rem_shift = {rem_q, 1'b0};
  assign rem_ge    = rem_shift >= {1'b0, div_q};
  assign rem_next  = rem_ge ? (rem_shift - {1'b0, div_q}) : rem_shift;

  // Out-of-range captures still run the full 8 steps. Only the result is masked.
  assign q_final = guard_q ? 8'd0 : quo_q;

  // Waveform shaping. 255-q equals ~q in 8 bits. The triangle doubles
  // whichever half it is in, so it peaks at 254 near q = 127/128.
  always_comb begin
    raw = q_final;
    case (mode_q)
      2'd0:    raw = q_final[7] ? 8'd0 : 8'd255;
      2'd1:    raw = q_final;
      2'd2:    raw = q_final[7] ? {~q_final[6:0], 1'b0} : {q_final[6:0], 1'b0};
      default: raw = ~q_final;
    endcase
  end

`ifdef SYNTH_ENV_EN
  typedef enum logic [1:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_state_e;

  env_state_e  state_q, state_d;
  logic        note_q;
  logic        note_rise;
  logic        note_fall;
  logic [7:0]  a_step;
  logic [7:0]  r_step;
  logic [8:0]  env_sum;
  logic [16:0] product;

  assign note_rise = note_on && !note_q;
  assign note_fall = !note_on && note_q;
  assign a_step    = (attack_step  == 8'd0) ? 8'd255 : attack_step;
  assign r_step    = (release_step == 8'd0) ? 8'd255 : release_step;
  assign env_sum   = {1'b0, env_q} + {1'b0, a_step};

  // Gate edges pick the state first. A coincident env_tick then applies the
  // step of the new state, which is why the case selects on state_d.
  // NOTE: every variable written in always_comb gets its default value at the
  // top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (note_rise) begin
      state_d = ENV_ATTACK;
    end else if (note_fall && (state_q == ENV_ATTACK || state_q == ENV_SUSTAIN)) begin
      state_d = ENV_RELEASE;
    end
    case (state_d)
      ENV_ATTACK: begin
        if (env_tick) begin
          env_d = env_sum[8] ? 8'd255 : env_sum[7:0];
          if (env_d == 8'd255) state_d = ENV_SUSTAIN;
        end
      end
      ENV_RELEASE: begin
        if (env_tick) begin
          env_d = (env_q > r_step) ? (env_q - r_step) : 8'd0;
          if (env_d == 8'd0) state_d = ENV_IDLE;
        end
      end
      ENV_SUSTAIN: env_d = 8'd255;
      default:     env_d = 8'd0;
    endcase
  end

  // (env_level + 1) lets a full-scale envelope pass raw unchanged.
  assign product = {9'd0, raw} * ({9'd0, env_q} + 17'd1);
  assign scaled  = product[15:8];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ENV_IDLE;
      note_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_on;
    end
  end

  assign unused_bits = ^{product[16], product[7:0], rem_next[16]};
`else
  assign env_d  = note_on ? 8'd255 : 8'd0;
  assign scaled = note_on ? raw : 8'd0;

  assign unused_bits = ^{env_tick, attack_step, release_step, rem_next[16]};
`endif

  always_comb begin
    busy_d   = busy_q;
    iter_d   = iter_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    mode_d   = mode_q;
    guard_d  = guard_q;
    sample_d = sample_q;
    valid_d  = 1'b0;

    if (busy_q && !finish) begin
      rem_d  = rem_next[15:0];
      quo_d  = {quo_q[6:0], rem_ge};
      iter_d = iter_q + 4'd1;
    end

    // Scaling uses the envelope level present on the completing edge.
    if (finish) begin
      sample_d = scaled;
      valid_d  = 1'b1;
      busy_d   = 1'b0;
    end

    if (accept) begin
      busy_d  = 1'b1;
      iter_d  = 4'd0;
      rem_d   = (count == 16'd0) ? 16'd0 : (count - 16'd1);
      div_d   = divider;
      mode_d  = mode;
      quo_d   = 8'd0;
      guard_d = (divider == 16'd0) || (count > divider);
    end
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // its _d value from before the edge, regardless of statement order.
  // NOTE: reset is synchronous and clears every register here, including the
  // datapath, so an in-flight division is discarded cleanly.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      busy_q   <= 1'b0;
      iter_q   <= 4'd0;
      rem_q    <= 16'd0;
      div_q    <= 16'd0;
      quo_q    <= 8'd0;
      mode_q   <= 2'd0;
      guard_q  <= 1'b0;
      sample_q <= 8'd0;
      valid_q  <= 1'b0;
      env_q    <= 8'd0;
    end else begin
      busy_q   <= busy_d;
      iter_q   <= iter_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      mode_q   <= mode_d;
      guard_q  <= guard_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      env_q    <= env_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign env_level    = env_q;

endmodule

// File: tb/tb_wave_shaper.sv
// -----------------------------------------------------------------------------
// tb_wave_shaper
//
// Testbench for wave_shaper. Inputs are driven, and outputs sampled, on the
// falling clock edge. Expected samples come from a plain-arithmetic reference
// (integer division, then the waveform formulas, then the envelope scale).
// Define SYNTH_ENV_EN for both the DUT and the bench to check the envelope
// build.
// -----------------------------------------------------------------------------
module tb_wave_shaper;

  logic        clk;
  logic        nrst;
  logic [15:0] count;
  logic [15:0] divider;
  logic        note_on;
  logic [1:0]  mode;
  logic        sample_tick;
  logic        env_tick;
  logic [7:0]  attack_step;
  logic [7:0]  release_step;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        busy;
  logic [7:0]  env_level;

  int n_cmp = 0;
  int n_bad = 0;
  int m_env = 0;

  wave_shaper dut (
    .clk          (clk),
    .nrst         (nrst),
    .count        (count),
    .divider      (divider),
    .note_on      (note_on),
    .mode         (mode),
    .sample_tick  (sample_tick),
    .env_tick     (env_tick),
    .attack_step  (attack_step),
    .release_step (release_step),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .env_level    (env_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier that the reference applies to the raw waveform (out of 256).
  function automatic int env_scale();
`ifdef SYNTH_ENV_EN
    return m_env + 1;
`else
    return note_on ? 256 : 0;
`endif
  endfunction

  function automatic int ref_sample(int c, int d, int m, int scale);
    int p, q, raw;
    p = (c == 0) ? 0 : c - 1;
    if (d == 0 || c > d) q = 0;
    else                 q = (p * 256) / d;
    case (m)
      0:       raw = (q < 128) ? 255 : 0;
      1:       raw = q;
      2:       raw = (q < 128) ? 2 * q : 2 * (255 - q);
      default: raw = 255 - q;
    endcase
    return (raw * scale) / 256;
  endfunction

  // Issues one request, scrambles the inputs after capture, and then watches
  // 12 cycles. An optional extra tick is raised for the edge k+extra.
  task automatic run_sample(input int c, input int d, input int m, input int extra,
                            output int got, output int pulses, output int lat);
    @(negedge clk);
    count       = c[15:0];
    divider     = d[15:0];
    mode        = m[1:0];
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    count       = 16'($urandom);
    divider     = 16'($urandom);
    mode        = 2'($urandom);
    got    = -1;
    pulses = 0;
    lat    = 0;
    for (int i = 1; i <= 12; i++) begin
      sample_tick = (i == extra);
      @(negedge clk);
      if (sample_valid) begin
        pulses++;
        if (lat == 0) begin
          lat = i;
          got = int'(sample);
        end
      end
    end
    sample_tick = 1'b0;
  endtask

  task automatic env_cycle(input logic n, input logic t);
    note_on  = n;
    env_tick = t;
    @(negedge clk);
    env_tick = 1'b0;
  endtask

  task automatic go_sustain();
    attack_step = 8'd0;
    env_cycle(1'b0, 1'b0);
    env_cycle(1'b1, 1'b1);
    m_env = 255;
    n_cmp++;
    if (env_level !== 8'd255) begin
      n_bad++;
      $display("FAIL go_sustain env_level: got %0d expected 255", env_level);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    count = '0; divider = '0; note_on = 1'b0; mode = '0;
    sample_tick = 1'b0; env_tick = 1'b0; attack_step = '0; release_step = '0;
    repeat (3) @(negedge clk);
    n_cmp += 4;
    if (sample !== 8'd0) begin n_bad++; $display("FAIL reset sample: got %0d expected 0", sample); end
    if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL reset valid: got %b expected 0", sample_valid); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b expected 0", busy); end
    if (env_level !== 8'd0) begin n_bad++; $display("FAIL reset env_level: got %0d expected 0", env_level); end
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sawtooth();
    int got, pulses, lat;
    run_sample(501, 1000, 1, 0, got, pulses, lat);
    n_cmp += 4;
    if (got !== 128) begin n_bad++; $display("FAIL sawtooth value: got %0d expected 128", got); end
    if (lat !== 9) begin n_bad++; $display("FAIL sawtooth latency: got %0d expected 9", lat); end
    if (pulses !== 1) begin n_bad++; $display("FAIL sawtooth pulses: got %0d expected 1", pulses); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL sawtooth busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_shapes();
    int modes [4] = '{2, 0, 3, 1};
    int exps  [4] = '{110, 0, 55, 200};
    int got, pulses, lat;
    for (int i = 0; i < 4; i++) begin
      run_sample(201, 256, modes[i], 0, got, pulses, lat);
      n_cmp++;
      if (got !== exps[i]) begin
        n_bad++;
        $display("FAIL shape mode%0d: got %0d expected %0d", modes[i], got, exps[i]);
      end
    end
  endtask

  task automatic test_guards();
    int got, pulses, lat;
    run_sample(5, 0, 1, 0, got, pulses, lat);
    n_cmp += 2;
    if (got !== 0) begin n_bad++; $display("FAIL guard div0 value: got %0d expected 0", got); end
    if (lat !== 9) begin n_bad++; $display("FAIL guard div0 latency: got %0d expected 9", lat); end
    run_sample(1200, 1000, 1, 0, got, pulses, lat);
    n_cmp++;
    if (got !== 0) begin n_bad++; $display("FAIL guard count_gt_div: got %0d expected 0", got); end
    run_sample(501, 1000, 1, 4, got, pulses, lat);
    n_cmp += 3;
    if (pulses !== 1) begin n_bad++; $display("FAIL busy_drop pulses: got %0d expected 1", pulses); end
    if (lat !== 9) begin n_bad++; $display("FAIL busy_drop latency: got %0d expected 9", lat); end
    if (got !== 128) begin n_bad++; $display("FAIL busy_drop value: got %0d expected 128", got); end
  endtask

  task automatic test_back_to_back();
    int pulses, i1, v1, i2, v2;
    int e1, e2;
    e1 = ref_sample(501, 1000, 1, env_scale());
    e2 = ref_sample(201, 256, 2, env_scale());
    @(negedge clk);
    count = 16'd501; divider = 16'd1000; mode = 2'd1; sample_tick = 1'b1;
    @(negedge clk);
    count = 16'd201; divider = 16'd256; mode = 2'd2;
    pulses = 0; i1 = 0; v1 = -1; i2 = 0; v2 = -1;
    for (int i = 1; i <= 20; i++) begin
      sample_tick = (i == 5) || (i == 9);
      @(negedge clk);
      if (i == 10) begin
        count = 16'($urandom); divider = 16'($urandom); mode = 2'($urandom);
      end
      if (sample_valid) begin
        pulses++;
        if (pulses == 1) begin i1 = i; v1 = int'(sample); end
        else if (pulses == 2) begin i2 = i; v2 = int'(sample); end
      end
    end
    sample_tick = 1'b0;
    n_cmp += 5;
    if (pulses !== 2) begin n_bad++; $display("FAIL b2b pulses: got %0d expected 2", pulses); end
    if (i1 !== 9) begin n_bad++; $display("FAIL b2b first_latency: got %0d expected 9", i1); end
    if (v1 !== e1) begin n_bad++; $display("FAIL b2b first_value: got %0d expected %0d", v1, e1); end
    if (i2 !== 18) begin n_bad++; $display("FAIL b2b second_latency: got %0d expected 18", i2); end
    if (v2 !== e2) begin n_bad++; $display("FAIL b2b second_value: got %0d expected %0d", v2, e2); end
  endtask

  task automatic test_reset_mid_div();
    int pulses;
    @(negedge clk);
    count = 16'd301; divider = 16'd400; mode = 2'd3; sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    n_cmp += 3;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset busy: got %b expected 0", busy); end
    if (sample !== 8'd0) begin n_bad++; $display("FAIL mid_reset sample: got %0d expected 0", sample); end
    if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset valid: got %b expected 0", sample_valid); end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sample_valid) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL mid_reset late_pulse: got %0d expected 0", pulses); end
    go_sustain();
  endtask

  task automatic test_envelope();
`ifdef SYNTH_ENV_EN
    int exps [9] = '{0, 0, 100, 200, 255, 255, 55, 0, 0};
    int got  [9];
    release_step = 8'd0;
    env_cycle(1'b0, 1'b0);                 // SUSTAIN -> RELEASE, level held
    env_cycle(1'b0, 1'b1); got[0] = int'(env_level);  // step 0 means 255
    env_cycle(1'b1, 1'b0); got[1] = int'(env_level);  // rise -> ATTACK, level kept
    attack_step = 8'd100;
    env_cycle(1'b1, 1'b1); got[2] = int'(env_level);
    env_cycle(1'b1, 1'b1); got[3] = int'(env_level);
    env_cycle(1'b1, 1'b1); got[4] = int'(env_level);
    env_cycle(1'b1, 1'b1); got[5] = int'(env_level);
    release_step = 8'd200;
    env_cycle(1'b0, 1'b1); got[6] = int'(env_level);  // fall and tick together
    env_cycle(1'b0, 1'b1); got[7] = int'(env_level);
    env_cycle(1'b0, 1'b1); got[8] = int'(env_level);
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (got[i] !== exps[i]) begin
        n_bad++;
        $display("FAIL env step%0d: got %0d expected %0d", i, got[i], exps[i]);
      end
    end
    attack_step = 8'd0;
    env_cycle(1'b1, 1'b1);
    n_cmp++;
    if (env_level !== 8'd255) begin n_bad++; $display("FAIL env rise_tick_step0: got %0d expected 255", env_level); end
    m_env = 255;
`else
    env_cycle(1'b0, 1'b1);
    n_cmp++;
    if (env_level !== 8'd0) begin n_bad++; $display("FAIL env gate_off: got %0d expected 0", env_level); end
    note_on = 1'b1;
    #1;
    n_cmp++;
    if (env_level !== 8'd0) begin n_bad++; $display("FAIL env not_yet_registered: got %0d expected 0", env_level); end
    @(negedge clk);
    n_cmp++;
    if (env_level !== 8'd255) begin n_bad++; $display("FAIL env gate_on: got %0d expected 255", env_level); end
    attack_step = 8'd10; release_step = 8'd10;
    env_cycle(1'b1, 1'b1);
    n_cmp++;
    if (env_level !== 8'd255) begin n_bad++; $display("FAIL env tick_ignored: got %0d expected 255", env_level); end
`endif
  endtask

  task automatic test_scaling();
    int got, pulses, lat, exp_v;
`ifdef SYNTH_ENV_EN
    release_step = 8'd128;
    env_cycle(1'b0, 1'b1);
    m_env = 127;
    exp_v = 100;
    n_cmp++;
    if (env_level !== 8'd127) begin n_bad++; $display("FAIL scale env_level: got %0d expected 127", env_level); end
`else
    note_on = 1'b1;
    exp_v = 200;
`endif
    run_sample(201, 256, 1, 0, got, pulses, lat);
    n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL scale value: got %0d expected %0d", got, exp_v); end
    go_sustain();
  endtask

  task automatic test_random();
    int c, d, m, got, pulses, lat, exp_v;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       d = int'($urandom_range(1, 300));
        1:       d = int'($urandom_range(1, 65535));
        2:       d = 0;
        default: d = 65535;
      endcase
      if ($urandom_range(0, 3) != 0 || d == 65535) c = int'($urandom_range(0, d));
      else                                          c = d + int'($urandom_range(1, 100));
      if (c > 65535) c = 65535;
      m = int'($urandom_range(0, 3));
`ifndef SYNTH_ENV_EN
      note_on = ($urandom_range(0, 3) != 0);
`endif
      exp_v = ref_sample(c, d, m, env_scale());
      run_sample(c, d, m, 0, got, pulses, lat);
      n_cmp += 2;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL random c=%0d d=%0d m=%0d: got %0d expected %0d", c, d, m, got, exp_v);
      end
      if (lat !== 9) begin
        n_bad++;
        $display("FAIL random latency: got %0d expected 9", lat);
      end
    end
  endtask

  initial begin
    test_reset();
    go_sustain();
    test_sawtooth();
    test_shapes();
    test_guards();
    test_back_to_back();
    test_reset_mid_div();
    test_envelope();
    test_scaling();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
